// File: rtl/pipe_hazard_scoreboard_if.sv
// Hazard-controller bundle: ID-stage instruction fields and pipeline status in,
// stall/flush enables and EX forwarding selects out.
interface pipe_hazard_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 2
);
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs_addr;
  logic [ADDR_W-1:0] id_rt_addr;
  logic              id_rs_used;
  logic              id_rt_used;
  logic [ADDR_W-1:0] id_dst_addr;
  logic              id_reg_write;
  logic              id_is_load;
  logic              flush;
  logic              mem_ready;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_clear;
  logic              id_ex_bubble;
  logic [SEL_W-1:0]  fwd_a_sel;
  logic [SEL_W-1:0]  fwd_b_sel;
  logic [31:0]       stall_count;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           id_dst_addr, id_reg_write, id_is_load, flush, mem_ready,
    input  pc_write, if_id_write, if_id_clear, id_ex_bubble,
           fwd_a_sel, fwd_b_sel, stall_count
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           id_dst_addr, id_reg_write, id_is_load, flush, mem_ready,
    output pc_write, if_id_write, if_id_clear, id_ex_bubble,
           fwd_a_sel, fwd_b_sel, stall_count
  );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// Scoreboard-based hazard/forwarding controller: tracks in-flight destinations
// from EX to WB, raises load-use stalls, applies flush/freeze, picks EX forwards.
module pipe_hazard_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int NSTAGE   = 3,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = 2
) (
    input logic clk,
    input logic rst,
    pipe_hazard_scoreboard_if.slave hz
);

    // Valid bits are the only scoreboard state that needs reset; the
    // payload fields are always qualified by them.
    logic [NSTAGE-1:0] sb_v;
    logic [NSTAGE-1:0] sb_we;
    logic [NSTAGE-1:0] sb_ld;
    logic [ADDR_W-1:0] sb_dst [NSTAGE];
    logic [ADDR_W-1:0] sb0_src_a;
    logic [ADDR_W-1:0] sb0_src_b;
    logic              sb0_ua;
    logic              sb0_ub;

    logic              pend_flush;
    logic [31:0]       stall_count;

    logic              hazard;
    logic              stall;
    logic              pc_write;
    logic              if_id_write;
    logic              if_id_clear;
    logic              id_ex_bubble;
    logic [SEL_W-1:0]  fwd_a_sel;
    logic [SEL_W-1:0]  fwd_b_sel;

    function automatic int avail(input logic ld);
        return ld ? LOAD_LAT + 1 : 1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    // ID stage: a producer whose result is not ready by the time the ID
    // instruction reaches EX forces a stall.
    always_comb begin
        hazard = 1'b0;
        for (int j = 0; j < NSTAGE; j++) begin
            if (sb_v[j] && sb_we[j] && sb_dst[j] != '0 && (j + 1 < avail(sb_ld[j]))) begin
                if (hz.id_rs_used && sb_dst[j] == hz.id_rs_addr) hazard = 1'b1;
                if (hz.id_rt_used && sb_dst[j] == hz.id_rt_addr) hazard = 1'b1;
            end
        end
        hazard = hazard & hz.id_valid;
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_clear  = 1'b0;
        id_ex_bubble = 1'b0;
        stall        = 1'b0;
        if (rst) begin
            pc_write = 1'b1;
        end else if (!hz.mem_ready) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (hz.flush || pend_flush) begin
            if_id_clear  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (hazard) begin
            stall        = 1'b1;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // EX stage: youngest forwardable producer wins; scan oldest-first so the
    // last hit is the youngest.
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        for (int k = NSTAGE - 1; k >= 1; k--) begin
            if (sb_v[k] && sb_we[k] && sb_dst[k] != '0 && k >= avail(sb_ld[k])) begin
                if (sb0_ua && sb_dst[k] == sb0_src_a) fwd_a_sel = SEL_W'(k);
                if (sb0_ub && sb_dst[k] == sb0_src_b) fwd_b_sel = SEL_W'(k);
            end
        end
        if (!sb_v[0]) begin
            fwd_a_sel = '0;
            fwd_b_sel = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_v        <= '0;
            pend_flush  <= 1'b0;
            stall_count <= '0;
        end else if (hz.mem_ready) begin
            sb_v       <= {sb_v[NSTAGE-2:0], hz.id_valid & ~id_ex_bubble};
            pend_flush <= 1'b0;
            if (stall) stall_count <= sat_inc(stall_count);
        end else begin
            pend_flush <= pend_flush | hz.flush;
        end
    end

    always_ff @(posedge clk) begin
        if (hz.mem_ready) begin
            sb_we <= {sb_we[NSTAGE-2:0], hz.id_reg_write};
            sb_ld <= {sb_ld[NSTAGE-2:0], hz.id_is_load};
            for (int j = NSTAGE - 1; j >= 1; j--) sb_dst[j] <= sb_dst[j-1];
            sb_dst[0] <= hz.id_dst_addr;
            sb0_src_a <= hz.id_rs_addr;
            sb0_src_b <= hz.id_rt_addr;
            sb0_ua    <= hz.id_rs_used;
            sb0_ub    <= hz.id_rt_used;
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.if_id_write  = if_id_write;
    assign hz.if_id_clear  = if_id_clear;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.fwd_a_sel    = fwd_a_sel;
    assign hz.fwd_b_sel    = fwd_b_sel;
    assign hz.stall_count  = stall_count;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench for pipe_hazard_scoreboard: two configurations (NSTAGE=3/LOAD_LAT=1 and
// NSTAGE=4/LOAD_LAT=2) driven by the same stimulus and checked against a model.
module tb_pipe_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       id_valid = 0, id_rs_used = 0, id_rt_used = 0, id_reg_write = 0, id_is_load = 0;
  logic       flush = 0, mem_ready = 1;
  logic [4:0] id_rs_addr = 0, id_rt_addr = 0, id_dst_addr = 0;

  pipe_hazard_scoreboard_if #(.ADDR_W(5), .SEL_W(2)) if0 ();
  pipe_hazard_scoreboard_if #(.ADDR_W(5), .SEL_W(2)) if1 ();

  assign if0.id_valid = id_valid;       assign if1.id_valid = id_valid;
  assign if0.id_rs_addr = id_rs_addr;   assign if1.id_rs_addr = id_rs_addr;
  assign if0.id_rt_addr = id_rt_addr;   assign if1.id_rt_addr = id_rt_addr;
  assign if0.id_rs_used = id_rs_used;   assign if1.id_rs_used = id_rs_used;
  assign if0.id_rt_used = id_rt_used;   assign if1.id_rt_used = id_rt_used;
  assign if0.id_dst_addr = id_dst_addr; assign if1.id_dst_addr = id_dst_addr;
  assign if0.id_reg_write = id_reg_write; assign if1.id_reg_write = id_reg_write;
  assign if0.id_is_load = id_is_load;   assign if1.id_is_load = id_is_load;
  assign if0.flush = flush;             assign if1.flush = flush;
  assign if0.mem_ready = mem_ready;     assign if1.mem_ready = mem_ready;

  pipe_hazard_scoreboard #(.ADDR_W(5), .NSTAGE(3), .LOAD_LAT(1), .SEL_W(2)) dut0 (
    .clk(clk), .rst(rst), .hz(if0.slave));
  pipe_hazard_scoreboard #(.ADDR_W(5), .NSTAGE(4), .LOAD_LAT(2), .SEL_W(2)) dut1 (
    .clk(clk), .rst(rst), .hz(if1.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: per configuration, list of in-flight instructions by
  // pipeline position after ID (0 = EX).
  int         nst[2] = '{3, 4};
  int         ll[2]  = '{1, 2};
  bit         m_v[2][4], m_we[2][4], m_ld[2][4];
  logic [4:0] m_dst[2][4];
  logic [4:0] m_sa[2], m_sb[2];
  bit         m_ua[2], m_ub[2], m_pend[2];
  logic [31:0] m_cnt[2];

  logic [7:0]  ctl_act[2];
  logic [31:0] cnt_act[2];
  assign ctl_act[0] = {if0.pc_write, if0.if_id_write, if0.if_id_clear, if0.id_ex_bubble, if0.fwd_a_sel, if0.fwd_b_sel};
  assign ctl_act[1] = {if1.pc_write, if1.if_id_write, if1.if_id_clear, if1.id_ex_bubble, if1.fwd_a_sel, if1.fwd_b_sel};
  assign cnt_act[0] = if0.stall_count;
  assign cnt_act[1] = if1.stall_count;

  function automatic int ready_at(input int c, input bit ld);
    return ld ? ll[c] + 1 : 1;
  endfunction

  function automatic logic [1:0] fwd_of(input int c, input logic [4:0] s, input bit used);
    if (!m_v[c][0] || !used) return 2'd0;
    for (int k = 1; k < nst[c]; k++)
      if (m_v[c][k] && m_we[c][k] && m_dst[c][k] != 0 && m_dst[c][k] == s && k >= ready_at(c, m_ld[c][k]))
        return 2'(k);
    return 2'd0;
  endfunction

  bit         e_hz, e_fe, e_st;
  logic [7:0] e_ctl;

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        for (int j = 0; j < 4; j++) m_v[c][j] = 0;
        m_pend[c] = 0;
        m_cnt[c]  = 0;
        chk($sformatf("reset ctl cfg%0d", c), {24'd0, ctl_act[c]}, {24'd0, 8'b1100_0000});
        chk($sformatf("reset cnt cfg%0d", c), cnt_act[c], 32'd0);
      end else begin
        e_hz = 0;
        for (int j = 0; j < nst[c]; j++)
          if (id_valid && m_v[c][j] && m_we[c][j] && m_dst[c][j] != 0 && (j + 1 < ready_at(c, m_ld[c][j])) &&
              ((id_rs_used && m_dst[c][j] == id_rs_addr) || (id_rt_used && m_dst[c][j] == id_rt_addr)))
            e_hz = 1;
        e_fe  = mem_ready && (flush || m_pend[c]);
        e_st  = mem_ready && !e_fe && e_hz;
        e_ctl = {mem_ready && !e_st, mem_ready && !e_st, e_fe, e_fe || e_st,
                 fwd_of(c, m_sa[c], m_ua[c]), fwd_of(c, m_sb[c], m_ub[c])};
        chk($sformatf("ctl cfg%0d", c), {24'd0, ctl_act[c]}, {24'd0, e_ctl});
        chk($sformatf("cnt cfg%0d", c), cnt_act[c], m_cnt[c]);
        if (mem_ready) begin
          for (int j = nst[c] - 1; j >= 1; j--) begin
            m_v[c][j] = m_v[c][j-1]; m_we[c][j] = m_we[c][j-1];
            m_ld[c][j] = m_ld[c][j-1]; m_dst[c][j] = m_dst[c][j-1];
          end
          m_v[c][0] = id_valid && !(e_fe || e_st);
          m_we[c][0] = id_reg_write; m_ld[c][0] = id_is_load; m_dst[c][0] = id_dst_addr;
          m_sa[c] = id_rs_addr; m_sb[c] = id_rt_addr; m_ua[c] = id_rs_used; m_ub[c] = id_rt_used;
          m_pend[c] = 0;
          if (e_st && m_cnt[c] != 32'hFFFF_FFFF) m_cnt[c] = m_cnt[c] + 1;
        end else begin
          m_pend[c] = m_pend[c] || flush;
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [4:0] rs, input logic [4:0] rt, input bit ru, input bit tu,
                       input logic [4:0] dst, input bit we, input bit ld, input bit fl, input bit mr);
    @(posedge clk); #1;
    id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_rs_used = ru; id_rt_used = tu;
    id_dst_addr = dst; id_reg_write = we; id_is_load = ld; flush = fl; mem_ready = mr;
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    id_valid = 0; flush = 0; mem_ready = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("init pc_write", {31'd0, if0.pc_write}, 32'd1);
    chk("init bubble", {31'd0, if0.id_ex_bubble}, 32'd0);
    chk("init stall_count", if0.stall_count, 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // lw $7 ; and $8,$7,$1 (held in ID while stalled)
    drive(1, 29, 0, 1, 0, 7, 1, 1, 0, 1);
    chk("lw issue pc_write", {31'd0, if0.pc_write}, 32'd1);
    drive(1, 7, 1, 1, 1, 8, 1, 0, 0, 1);
    chk("lu stall pc_write", {31'd0, if0.pc_write}, 32'd0);
    chk("lu stall bubble", {31'd0, if0.id_ex_bubble}, 32'd1);
    chk("lu2 stall1 pc_write", {31'd0, if1.pc_write}, 32'd0);
    drive(1, 7, 1, 1, 1, 8, 1, 0, 0, 1);
    chk("lu after stall pc_write", {31'd0, if0.pc_write}, 32'd1);
    chk("lu stall_count", if0.stall_count, 32'd1);
    chk("lu2 stall2 pc_write", {31'd0, if1.pc_write}, 32'd0);
    drive(1, 7, 1, 1, 1, 8, 1, 0, 0, 1);
    chk("lu fwd_a", {30'd0, if0.fwd_a_sel}, 32'd2);
    chk("lu fwd_b", {30'd0, if0.fwd_b_sel}, 32'd0);
    chk("lu2 release pc_write", {31'd0, if1.pc_write}, 32'd1);
    chk("lu2 stall_count", if1.stall_count, 32'd2);
    nop();
    chk("lu2 fwd_a", {30'd0, if1.fwd_a_sel}, 32'd3);

    // add $2 ; add $5,$2,$2
    do_reset();
    drive(1, 1, 1, 1, 1, 2, 1, 0, 0, 1);
    drive(1, 2, 2, 1, 1, 5, 1, 0, 0, 1);
    chk("alu no stall", {31'd0, if0.pc_write}, 32'd1);
    nop();
    chk("alu fwd_a", {30'd0, if0.fwd_a_sel}, 32'd1);
    chk("alu fwd_b", {30'd0, if0.fwd_b_sel}, 32'd1);

    // add $2 ; sub $2 ; or $6,$2,$0
    do_reset();
    drive(1, 1, 1, 1, 1, 2, 1, 0, 0, 1);
    drive(1, 3, 4, 1, 1, 2, 1, 0, 0, 1);
    drive(1, 2, 0, 1, 1, 6, 1, 0, 0, 1);
    nop();
    chk("youngest fwd_a", {30'd0, if0.fwd_a_sel}, 32'd1);
    chk("r0 fwd_b", {30'd0, if0.fwd_b_sel}, 32'd0);

    // flush raised while memory is not ready
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("frozen enables", {28'd0, ctl_act[0][7:4]}, 32'b0000);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("pending flush applied", {28'd0, ctl_act[0][7:4]}, 32'b1111);
    nop();
    chk("flush once", {28'd0, ctl_act[0][7:4]}, 32'b1100);

    // async reset with a load sitting in EX
    do_reset();
    drive(1, 29, 0, 1, 0, 7, 1, 1, 0, 1);
    drive(1, 7, 1, 1, 1, 8, 1, 0, 0, 1);
    drive(1, 7, 1, 1, 1, 8, 1, 0, 0, 1);
    drive(1, 29, 0, 1, 0, 9, 1, 1, 0, 1);
    drive(1, 9, 0, 1, 1, 10, 1, 0, 0, 1);
    chk("pre-rst pc_write", {31'd0, if0.pc_write}, 32'd0);
    chk("pre-rst stall_count", if0.stall_count, 32'd1);
    rst = 1;
    #1;
    chk("async rst pc_write", {31'd0, if0.pc_write}, 32'd1);
    chk("async rst fwd", {30'd0, if0.fwd_a_sel | if0.fwd_b_sel}, 32'd0);
    chk("async rst stall_count", if0.stall_count, 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // randomized traffic with a small register pool to force collisions
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      rst          = ($urandom_range(0, 299) == 0);
      id_valid     = ($urandom_range(0, 9) != 0);
      id_rs_addr   = 5'($urandom_range(0, 3));
      id_rt_addr   = 5'($urandom_range(0, 3));
      id_rs_used   = $urandom_range(0, 1);
      id_rt_used   = $urandom_range(0, 1);
      id_dst_addr  = 5'($urandom_range(0, 3));
      id_reg_write = ($urandom_range(0, 3) != 0);
      id_is_load   = ($urandom_range(0, 2) == 0);
      flush        = ($urandom_range(0, 15) == 0);
      mem_ready    = ($urandom_range(0, 7) != 0);
    end
    @(posedge clk); #1;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
